// File: rtl/ssd1306_seq_pkg.sv
// Shared definitions for the SSD1306 SPI sequencer.
//   seq_state_t : sequencer FSM state encoding
//   INIT_TABLE  : power-up command table, element 0 is sent first
//   INIT_LEN    : number of entries in INIT_TABLE
//   DC_CMD/DC_DATA : D/C line encoding
// Optional feature macro: SSD1306_INIT_SEQ_EN adds the ST_INIT state.
package ssd1306_seq_pkg;

`ifdef SSD1306_INIT_SEQ_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_CS_SETUP, ST_LOAD, ST_SHIFT, ST_CS_HOLD, ST_CS_IDLE, ST_INIT
  } seq_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_CS_SETUP, ST_LOAD, ST_SHIFT, ST_CS_HOLD, ST_CS_IDLE
  } seq_state_t;
`endif

  localparam int INIT_LEN = 6;

  // Display off, charge pump on, horizontal addressing, display on.
  // Concatenation is written last-to-first so that INIT_TABLE[0] = 0xAE.
  localparam logic [INIT_LEN-1:0][7:0] INIT_TABLE = {
    8'hAF, 8'h00, 8'h20, 8'h14, 8'h8D, 8'hAE
  };

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

endpackage

// File: rtl/ssd1306_spi_sequencer.sv
// Sequences an external 8-bit serializer into SSD1306 SPI write bursts.
// Optional feature macro: SSD1306_INIT_SEQ_EN (sends the power-up command
// table as one burst after reset before accepting upstream bytes).
// Ports:
//   clk_in, reset_n_in          : clock, async active-low reset
//   byte_valid_in/data_in/dc_in : upstream byte, accepted with byte_ready_out
//   sr_start_out, sr_data_out   : start pulse and word to the serializer
//   sr_ready_in                 : serializer idle
//   cs_n_out, dc_out            : OLED chip select and D/C lines
//   busy_out, init_done_out     : status
//
// state       | meaning
// ST_IDLE     | cs high, ready for a new burst
// ST_INIT     | load first init-table byte, open the init burst
// ST_CS_SETUP | cs low, waiting CS_SETUP_CYCLES before first start
// ST_LOAD     | waiting for serializer ready, issue one start pulse
// ST_SHIFT    | serializer busy; completion cycle offers next accept
// ST_CS_HOLD  | cs low for CS_HOLD_CYCLES after the last byte
// ST_CS_IDLE  | cs high for CS_IDLE_CYCLES before returning to idle
module ssd1306_spi_sequencer
  import ssd1306_seq_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int CS_SETUP_CYCLES = 1,
  parameter int CS_HOLD_CYCLES  = 1,
  parameter int CS_IDLE_CYCLES  = 1
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic             byte_valid_in,
  input  logic [WIDTH-1:0] byte_data_in,
  input  logic             byte_dc_in,
  output logic             byte_ready_out,
  output logic             sr_start_out,
  output logic [WIDTH-1:0] sr_data_out,
  input  logic             sr_ready_in,
  output logic             cs_n_out,
  output logic             dc_out,
  output logic             busy_out,
  output logic             init_done_out
);

  localparam int MAX_SH = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES : CS_HOLD_CYCLES;
  localparam int MAX_CYCLES = (MAX_SH > CS_IDLE_CYCLES) ? MAX_SH : CS_IDLE_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LD  = CNT_W'(CS_IDLE_CYCLES - 1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_busy_q, seen_busy_d;
  logic             cmpl_q, cmpl_d;
  logic             init_done_q, init_done_d;
  logic             cs_n_d, dc_d, sr_start_d, byte_ready_d, busy_d;
  logic [WIDTH-1:0] sr_data_d;
  logic             accept;
  logic             ready_en;

`ifdef SSD1306_INIT_SEQ_EN
  localparam int IDX_W = $clog2(INIT_LEN + 1);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(INIT_LEN);
  logic [IDX_W-1:0] idx_q, idx_d;
  assign ready_en = init_done_q;
`else
  assign ready_en = 1'b1;
`endif

  assign accept        = byte_valid_in & byte_ready_out;
  assign init_done_out = init_done_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    seen_busy_d  = seen_busy_q;
    cmpl_d       = 1'b0;
    cs_n_d       = cs_n_out;
    dc_d         = dc_out;
    sr_start_d   = 1'b0;
    sr_data_d    = sr_data_out;
    byte_ready_d = 1'b0;
`ifdef SSD1306_INIT_SEQ_EN
    init_done_d  = init_done_q;
    idx_d        = idx_q;
`else
    init_done_d  = 1'b1;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef SSD1306_INIT_SEQ_EN
        if (!init_done_q) state_d = ST_INIT;
        else
`endif
        if (accept) begin
          state_d   = ST_CS_SETUP;
          cnt_d     = SETUP_LD;
          cs_n_d    = 1'b0;
          dc_d      = byte_dc_in;
          sr_data_d = byte_data_in;
        end else begin
          byte_ready_d = ready_en;
        end
      end
`ifdef SSD1306_INIT_SEQ_EN
      ST_INIT: begin
        state_d   = ST_CS_SETUP;
        cnt_d     = SETUP_LD;
        cs_n_d    = 1'b0;
        dc_d      = DC_CMD;
        sr_data_d = WIDTH'(INIT_TABLE[0]);
        idx_d     = IDX_W'(1);
      end
`endif
      ST_CS_SETUP: begin
        // The start pulse is registered, so the ready decision is made
        // on the way into LOAD to hit the first LOAD cycle.
        if (cnt_q == '0) begin
          state_d    = ST_LOAD;
          sr_start_d = sr_ready_in;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_LOAD: begin
        if (sr_start_out) begin
          state_d     = ST_SHIFT;
          seen_busy_d = 1'b0;
        end else if (sr_ready_in) begin
          sr_start_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cmpl_q) begin
          // Completion cycle: byte_ready_out is high here (outside init).
`ifdef SSD1306_INIT_SEQ_EN
          if (!init_done_q && idx_q != IDX_END) begin
            state_d    = ST_LOAD;
            sr_data_d  = WIDTH'(INIT_TABLE[idx_q]);
            idx_d      = idx_q + IDX_W'(1);
            sr_start_d = sr_ready_in;
          end else
`endif
          if (accept) begin
            state_d    = ST_LOAD;
            dc_d       = byte_dc_in;
            sr_data_d  = byte_data_in;
            sr_start_d = sr_ready_in;
          end else begin
            state_d = ST_CS_HOLD;
            cnt_d   = HOLD_LD;
          end
        end else if (!sr_ready_in) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          cmpl_d       = 1'b1;
          byte_ready_d = ready_en;
        end
      end
      ST_CS_HOLD: begin
        if (cnt_q == '0) begin
          state_d     = ST_CS_IDLE;
          cnt_d       = IDLE_LD;
          cs_n_d      = 1'b1;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CS_IDLE: begin
        if (cnt_q == '0) begin
          state_d      = ST_IDLE;
          byte_ready_d = ready_en;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      seen_busy_q    <= 1'b0;
      cmpl_q         <= 1'b0;
      init_done_q    <= 1'b0;
      cs_n_out       <= 1'b1;
      dc_out         <= DC_CMD;
      sr_start_out   <= 1'b0;
      sr_data_out    <= '0;
      byte_ready_out <= 1'b0;
      busy_out       <= 1'b0;
`ifdef SSD1306_INIT_SEQ_EN
      idx_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      seen_busy_q    <= seen_busy_d;
      cmpl_q         <= cmpl_d;
      init_done_q    <= init_done_d;
      cs_n_out       <= cs_n_d;
      dc_out         <= dc_d;
      sr_start_out   <= sr_start_d;
      sr_data_out    <= sr_data_d;
      byte_ready_out <= byte_ready_d;
      busy_out       <= busy_d;
`ifdef SSD1306_INIT_SEQ_EN
      idx_q          <= idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_ssd1306_spi_sequencer.sv
// Self-checking bench for ssd1306_spi_sequencer with a behavioural 8-bit
// MSB-first serializer. Timing: completion cycle = cycle after the
// serializer's ready returns; next start follows one cycle later.
module tb_ssd1306_spi_sequencer;
  localparam int SETUP = 1;
  localparam int HOLD  = 1;
  localparam int IDLEC = 1;

  logic clk_in = 1'b0;
  logic reset_n_in;
  logic byte_valid_in, byte_dc_in, byte_ready_out;
  logic [7:0] byte_data_in, sr_data_out;
  logic sr_start_out, sr_ready_in, cs_n_out, dc_out, busy_out, init_done_out;

  ssd1306_spi_sequencer #(
    .WIDTH(8), .CS_SETUP_CYCLES(SETUP), .CS_HOLD_CYCLES(HOLD), .CS_IDLE_CYCLES(IDLEC)
  ) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .byte_valid_in(byte_valid_in), .byte_data_in(byte_data_in), .byte_dc_in(byte_dc_in),
    .byte_ready_out(byte_ready_out), .sr_start_out(sr_start_out), .sr_data_out(sr_data_out),
    .sr_ready_in(sr_ready_in), .cs_n_out(cs_n_out), .dc_out(dc_out),
    .busy_out(busy_out), .init_done_out(init_done_out)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk_in) cyc++;

  // Behavioural serializer: 8 shift cycles, MSB first, capture into rx_q.
  logic ser_ready, force_busy;
  logic [7:0] ser_sh, rx_sh;
  int ser_bits;
  logic [7:0] rx_q[$];
  assign sr_ready_in = ser_ready & ~force_busy;
  always @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      ser_ready <= 1'b1; ser_bits <= 0; ser_sh <= 8'h00; rx_sh <= 8'h00;
    end else if (sr_start_out && ser_ready) begin
      ser_sh <= sr_data_out; ser_bits <= 8; ser_ready <= 1'b0;
    end else if (ser_bits > 0) begin
      rx_sh <= {rx_sh[6:0], ser_sh[7]};
      ser_sh <= {ser_sh[6:0], 1'b0};
      ser_bits <= ser_bits - 1;
      if (ser_bits == 1) begin
        ser_ready <= 1'b1;
        rx_q.push_back({rx_sh[6:0], ser_sh[7]});
      end
    end
  end

  // Event log sampled mid-cycle.
  int st_cyc[$], fall_cyc[$], rise_cyc[$], acc_cyc[$], done_cyc[$];
  logic [7:0] st_data[$];
  logic st_dc[$], st_cs[$], done_dc[$];
  int init_done_cyc = -1;
  logic cs_prev = 1'b1, ser_prev = 1'b1, idn_prev = 1'b0;
  always @(negedge clk_in) begin
    if (sr_start_out) begin
      st_cyc.push_back(cyc); st_data.push_back(sr_data_out);
      st_dc.push_back(dc_out); st_cs.push_back(cs_n_out);
    end
    if (cs_n_out !== cs_prev) begin
      if (!cs_n_out) fall_cyc.push_back(cyc); else rise_cyc.push_back(cyc);
      cs_prev = cs_n_out;
    end
    if (byte_valid_in && byte_ready_out) acc_cyc.push_back(cyc);
    if (ser_ready && !ser_prev) begin done_cyc.push_back(cyc); done_dc.push_back(dc_out); end
    ser_prev = ser_ready;
    if (init_done_out && !idn_prev) init_done_cyc = cyc;
    idn_prev = init_done_out;
  end

  task automatic clear_log();
    st_cyc.delete(); fall_cyc.delete(); rise_cyc.delete(); acc_cyc.delete();
    done_cyc.delete(); st_data.delete(); st_dc.delete(); st_cs.delete();
    done_dc.delete(); rx_q.delete();
  endtask

  task automatic offer(input logic [7:0] d, input logic dc, input bit keep, output bit got);
    byte_data_in = d; byte_dc_in = dc; byte_valid_in = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk_in);
      if (byte_ready_out) got = 1'b1;
    end
    @(posedge clk_in); #1;
    if (!keep) byte_valid_in = 1'b0;
  endtask

  task automatic wait_quiet(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk_in);
      if (!busy_out && cs_n_out && ser_ready) ok = 1'b1;
    end
    @(posedge clk_in); #1;
  endtask

  task automatic post_reset_wait();
`ifdef SSD1306_INIT_SEQ_EN
    bit ok;
    for (int i = 0; i < 400 && !init_done_out; i++) @(negedge clk_in);
    wait_quiet(ok);
`else
    @(posedge clk_in); #1;
`endif
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (cs_n_out !== 1'b1) begin n_fail++; $display("FAIL reset_cs got %b want 1", cs_n_out); end
    n_tests++; if (dc_out !== 1'b0) begin n_fail++; $display("FAIL reset_dc got %b want 0", dc_out); end
    n_tests++; if (sr_start_out !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", sr_start_out); end
    n_tests++; if (sr_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", sr_data_out); end
    n_tests++; if (byte_ready_out !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", byte_ready_out); end
    n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_out); end
    n_tests++; if (init_done_out !== 1'b0) begin n_fail++; $display("FAIL reset_init_done got %b want 0", init_done_out); end
  endtask

  task automatic test_after_release();
    @(posedge clk_in); #1;
    n_tests++; if (init_done_out !== 1'b1) begin n_fail++; $display("FAIL rel_init_done got %b want 1", init_done_out); end
    n_tests++; if (byte_ready_out !== 1'b1) begin n_fail++; $display("FAIL rel_ready got %b want 1", byte_ready_out); end
  endtask

  task automatic test_init();
    bit ok;
    logic [7:0] tbl [6] = '{8'hAE, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hAF};
    for (int i = 0; i < 600 && !init_done_out; i++) @(negedge clk_in);
    n_tests++; if (init_done_out !== 1'b1) begin n_fail++; $display("FAIL init_done got %b want 1", init_done_out); end
    for (int i = 0; i < 50 && acc_cyc.size() == 0; i++) @(negedge clk_in);
    @(posedge clk_in); #1; byte_valid_in = 1'b0;
    wait_quiet(ok);
    n_tests++; if (st_cyc.size() != 7) begin n_fail++; $display("FAIL init_starts got %0d want 7", st_cyc.size()); end
    for (int i = 0; i < 6; i++) begin
      n_tests++; if (st_data[i] !== tbl[i] || st_dc[i] !== 1'b0) begin
        n_fail++; $display("FAIL init_byte%0d got %h/dc%b want %h/dc0", i, st_data[i], st_dc[i], tbl[i]); end
      n_tests++; if (rx_q[i] !== tbl[i]) begin n_fail++; $display("FAIL init_rx%0d got %h want %h", i, rx_q[i], tbl[i]); end
    end
    n_tests++; if (fall_cyc.size() != 2 || !(fall_cyc[0] < st_cyc[0]) || !(rise_cyc[0] > st_cyc[5]) || !(fall_cyc[1] > rise_cyc[0])) begin
      n_fail++; $display("FAIL init_burst falls %0d rises %0d want 2 bursts, table in first", fall_cyc.size(), rise_cyc.size()); end
    n_tests++; if (acc_cyc.size() != 1 || acc_cyc[0] < init_done_cyc || init_done_cyc <= done_cyc[5]) begin
      n_fail++; $display("FAIL init_accept acc %0d init_done %0d want acc after init_done", acc_cyc[0], init_done_cyc); end
    n_tests++; if (rx_q[6] !== 8'h5A || st_dc[6] !== 1'b1) begin n_fail++; $display("FAIL init_user got %h/dc%b want 5a/dc1", rx_q[6], st_dc[6]); end
  endtask

  task automatic test_single();
    bit got, ok;
    clear_log();
    offer(8'hA5, 1'b1, 1'b0, got);
    wait_quiet(ok);
    n_tests++; if (!(got && ok)) begin n_fail++; $display("FAIL single_timeout got %b%b want 11", got, ok); end
    n_tests++; if (st_cyc.size() != 1 || st_data[0] !== 8'hA5) begin n_fail++; $display("FAIL single_start n=%0d data %h want 1/a5", st_cyc.size(), st_data[0]); end
    n_tests++; if (st_cyc[0] != acc_cyc[0] + 1 + SETUP) begin n_fail++; $display("FAIL single_latency got %0d want %0d", st_cyc[0], acc_cyc[0] + 1 + SETUP); end
    n_tests++; if (fall_cyc[0] != acc_cyc[0] + 1) begin n_fail++; $display("FAIL single_cs_fall got %0d want %0d", fall_cyc[0], acc_cyc[0] + 1); end
    n_tests++; if (rise_cyc[0] != done_cyc[0] + 2 + HOLD) begin n_fail++; $display("FAIL single_cs_rise got %0d want %0d", rise_cyc[0], done_cyc[0] + 2 + HOLD); end
    n_tests++; if (st_dc[0] !== 1'b1 || done_dc[0] !== 1'b1) begin n_fail++; $display("FAIL single_dc got %b%b want 11", st_dc[0], done_dc[0]); end
    n_tests++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin n_fail++; $display("FAIL single_rx got %h want a5", rx_q[0]); end
  endtask

  task automatic test_back_to_back();
    bit g0, g1, g2, ok;
    logic [7:0] d [3] = '{8'h00, 8'h10, 8'hFF};
    logic       c [3] = '{1'b0, 1'b0, 1'b1};
    clear_log();
    offer(d[0], c[0], 1'b1, g0);
    offer(d[1], c[1], 1'b1, g1);
    offer(d[2], c[2], 1'b0, g2);
    wait_quiet(ok);
    n_tests++; if (!(g0 && g1 && g2 && ok)) begin n_fail++; $display("FAIL b2b_timeout got %b%b%b%b want 1111", g0, g1, g2, ok); end
    n_tests++; if (fall_cyc.size() != 1 || rise_cyc.size() != 1) begin n_fail++; $display("FAIL b2b_bursts falls %0d rises %0d want 1/1", fall_cyc.size(), rise_cyc.size()); end
    n_tests++; if (st_cyc.size() != 3) begin n_fail++; $display("FAIL b2b_starts got %0d want 3", st_cyc.size()); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (st_data[i] !== d[i] || st_dc[i] !== c[i] || rx_q[i] !== d[i]) begin
        n_fail++; $display("FAIL b2b_byte%0d got %h/%h/dc%b want %h/dc%b", i, st_data[i], rx_q[i], st_dc[i], d[i], c[i]); end
    end
    for (int i = 1; i < 3; i++) begin
      n_tests++; if (st_cyc[i] != done_cyc[i-1] + 2) begin n_fail++; $display("FAIL b2b_gap%0d got %0d want %0d", i, st_cyc[i], done_cyc[i-1] + 2); end
    end
    n_tests++; if (done_dc[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_dc_early got %b want 0", done_dc[1]); end
  endtask

  task automatic test_gap();
    bit g0, g1, ok0, ok1;
    clear_log();
    offer(8'h11, 1'b1, 1'b0, g0);
    wait_quiet(ok0);
    repeat ($urandom_range(0, 3)) begin @(posedge clk_in); #1; end
    offer(8'h22, 1'b0, 1'b0, g1);
    wait_quiet(ok1);
    n_tests++; if (!(g0 && g1 && ok0 && ok1)) begin n_fail++; $display("FAIL gap_timeout got %b%b%b%b want 1111", g0, g1, ok0, ok1); end
    n_tests++; if (fall_cyc.size() != 2 || rise_cyc.size() != 2) begin n_fail++; $display("FAIL gap_bursts falls %0d rises %0d want 2/2", fall_cyc.size(), rise_cyc.size()); end
    n_tests++; if (fall_cyc[1] - rise_cyc[0] < IDLEC) begin n_fail++; $display("FAIL gap_cs_high got %0d want >=%0d", fall_cyc[1] - rise_cyc[0], IDLEC); end
    n_tests++; if (st_cyc[1] != acc_cyc[1] + 1 + SETUP) begin n_fail++; $display("FAIL gap_setup got %0d want %0d", st_cyc[1], acc_cyc[1] + 1 + SETUP); end
    n_tests++; if (rx_q[0] !== 8'h11 || rx_q[1] !== 8'h22) begin n_fail++; $display("FAIL gap_rx got %h %h want 11 22", rx_q[0], rx_q[1]); end
  endtask

  task automatic test_load_stall();
    bit got, ok;
    int rel;
    clear_log();
    force_busy = 1'b1;
    offer(8'h5C, 1'b1, 1'b0, got);
    repeat (6) @(posedge clk_in);
    #1; force_busy = 1'b0; rel = cyc;
    wait_quiet(ok);
    n_tests++; if (!(got && ok)) begin n_fail++; $display("FAIL stall_timeout got %b%b want 11", got, ok); end
    n_tests++; if (st_cyc.size() != 1) begin n_fail++; $display("FAIL stall_starts got %0d want 1", st_cyc.size()); end
    n_tests++; if (st_cyc[0] < rel || st_cyc[0] > rel + 1) begin n_fail++; $display("FAIL stall_start_cyc got %0d want %0d..%0d", st_cyc[0], rel, rel + 1); end
    n_tests++; if (rx_q[0] !== 8'h5C) begin n_fail++; $display("FAIL stall_rx got %h want 5c", rx_q[0]); end
  endtask

  task automatic test_reset_mid();
    bit got, ok, hit;
    offer(8'hC3, 1'b1, 1'b0, got);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk_in);
      if (ser_bits == 5) hit = 1'b1;
    end
    #2 reset_n_in = 1'b0;
    #1;
    n_tests++; if (!hit) begin n_fail++; $display("FAIL rstmid_reach got %b want 1", hit); end
    n_tests++; if (cs_n_out !== 1'b1 || byte_ready_out !== 1'b0 || busy_out !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async cs%b rdy%b busy%b want 1 0 0", cs_n_out, byte_ready_out, busy_out); end
    repeat (2) @(negedge clk_in);
    #2 reset_n_in = 1'b1;
    post_reset_wait();
`ifndef SSD1306_INIT_SEQ_EN
    n_tests++; if (busy_out !== 1'b0 || byte_ready_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle busy%b rdy%b want 0 1", busy_out, byte_ready_out); end
`endif
    clear_log();
    offer(8'h3C, 1'b0, 1'b0, got);
    wait_quiet(ok);
    n_tests++; if (!(got && ok) || st_data[0] !== 8'h3C || rx_q[0] !== 8'h3C || st_dc[0] !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_next got %h/%h dc%b want 3c/3c dc0", st_data[0], rx_q[0], st_dc[0]); end
    n_tests++; if (st_cyc[0] != acc_cyc[0] + 1 + SETUP) begin n_fail++; $display("FAIL rstmid_latency got %0d want %0d", st_cyc[0], acc_cyc[0] + 1 + SETUP); end
  endtask

  task automatic test_random();
    logic [7:0] exp_d[$];
    logic       exp_c[$];
    bit got, ok, all_got;
    int gap;
    clear_log();
    all_got = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_d.push_back(8'($urandom));
      exp_c.push_back(1'($urandom));
      gap = (i == 15) ? 1 : int'($urandom_range(0, 3));
      offer(exp_d[i], exp_c[i], gap == 0, got);
      all_got &= got;
      repeat (gap) begin @(posedge clk_in); #1; end
    end
    wait_quiet(ok);
    n_tests++; if (!(all_got && ok)) begin n_fail++; $display("FAIL rand_timeout got %b%b want 11", all_got, ok); end
    n_tests++; if (rx_q.size() != 16 || st_cyc.size() != 16) begin n_fail++; $display("FAIL rand_count rx %0d starts %0d want 16", rx_q.size(), st_cyc.size()); end
    for (int i = 0; i < 16; i++) begin
      n_tests++; if (rx_q[i] !== exp_d[i] || st_dc[i] !== exp_c[i] || st_cs[i] !== 1'b0) begin
        n_fail++; $display("FAIL rand_byte%0d got %h dc%b cs%b want %h dc%b cs0", i, rx_q[i], st_dc[i], st_cs[i], exp_d[i], exp_c[i]); end
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset_n_in = 1'b0; byte_valid_in = 1'b0; byte_data_in = 8'h00;
    byte_dc_in = 1'b0; force_busy = 1'b0;
    repeat (3) @(posedge clk_in);
    test_reset();
    clear_log();
`ifdef SSD1306_INIT_SEQ_EN
    byte_data_in = 8'h5A; byte_dc_in = 1'b1; byte_valid_in = 1'b1;
    @(negedge clk_in); #2 reset_n_in = 1'b1;
    test_init();
`else
    @(negedge clk_in); #2 reset_n_in = 1'b1;
    test_after_release();
`endif
    test_single();
    test_back_to_back();
    test_gap();
    test_load_stall();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
